// File: rtl/ripple_count_sampler_if.sv
// Signal bundle between a ripple-counter sampler and its host: raw counter
// input, match/ack controls, and the sampled count/status outputs.
interface ripple_count_sampler_if;
  logic [3:0] q_in;
  logic [3:0] match_val;
  logic       match_en;
  logic       irq_ack;
  logic [7:0] count_out;
  logic       count_valid;
  logic       match_irq;
  logic       skip_err;

  modport master (
    output q_in,
    output match_val,
    output match_en,
    output irq_ack,
    input  count_out,
    input  count_valid,
    input  match_irq,
    input  skip_err
  );

  modport slave (
    input  q_in,
    input  match_val,
    input  match_en,
    input  irq_ack,
    output count_out,
    output count_valid,
    output match_irq,
    output skip_err
  );
endinterface

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous 4-bit ripple counter, accepts a value only after it
// has been stable for STABLE_CYCLES synchronised samples, and tracks wraps.
//
// state  | meaning
// IDLE   | synchronised sample equals the accepted value, nothing pending
// SETTLE | a new candidate is being qualified for stability
// ACCEPT | candidate qualified; commit it on the next edge
module ripple_count_sampler #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  ripple_count_sampler_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2
  } state_t;

  localparam logic [3:0] STABLE_TC = 4'(STABLE_CYCLES);

  state_t     state_q;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] cand_q;
  logic [3:0] stable_q;
  logic [3:0] wrap_q;
  logic [2:0] stab_cnt_q;
  logic       count_valid_q;
  logic       match_irq_q;
  logic       skip_err_q;

  logic [3:0] samp;
  logic [3:0] stab_cnt_d;
  logic [3:0] stable_inc;
  logic       step_ok;
  logic       wrap_step;
  logic       match_hit;

  assign samp       = sync_q[SYNC_STAGES-1];
  assign stab_cnt_d = {1'b0, stab_cnt_q} + 4'd1;
  assign stable_inc = stable_q + 4'd1;
  assign step_ok    = (cand_q == stable_inc);
  assign wrap_step  = step_ok && (stable_q == 4'hF);
  assign match_hit  = bus.match_en && (cand_q == bus.match_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'd0;
      end
      state_q       <= IDLE;
      cand_q        <= 4'd0;
      stable_q      <= 4'd0;
      wrap_q        <= 4'd0;
      stab_cnt_q    <= 3'd0;
      count_valid_q <= 1'b0;
      match_irq_q   <= 1'b0;
      skip_err_q    <= 1'b0;
    end else begin
      sync_q[0] <= bus.q_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end

      count_valid_q <= 1'b0;
      if (bus.irq_ack) begin
        match_irq_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (samp != stable_q) begin
            cand_q     <= samp;
            stab_cnt_q <= 3'd1;
            state_q    <= SETTLE;
          end
        end

        SETTLE: begin
          if (samp == cand_q) begin
            stab_cnt_q <= stab_cnt_d[2:0];
            if (stab_cnt_d >= STABLE_TC) begin
              state_q <= ACCEPT;
            end
          end else if (samp == stable_q) begin
            // Counter fell back to the accepted value: the candidate was a glitch.
            state_q <= IDLE;
          end else begin
            cand_q     <= samp;
            stab_cnt_q <= 3'd1;
          end
        end

        ACCEPT: begin
          stable_q      <= cand_q;
          count_valid_q <= 1'b1;
          if (wrap_step) begin
            wrap_q <= wrap_q + 4'd1;
          end
          if (!step_ok) begin
            skip_err_q <= 1'b1;
          end
          // Set takes priority over a same-cycle acknowledge.
          if (match_hit) begin
            match_irq_q <= 1'b1;
          end
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.count_out   = {wrap_q, stable_q};
  assign bus.count_valid = count_valid_q;
  assign bus.match_irq   = match_irq_q;
  assign bus.skip_err    = skip_err_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler with default parameters; expected
// values are hand-computed from the acceptance timing and step rules.
module tb_ripple_count_sampler;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   pulses;
  int   consec;
  logic prev_valid;

  ripple_count_sampler_if bus ();

  ripple_count_sampler #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted-value pulses and any back-to-back pulses.
  always @(negedge clk) begin
    if (bus.count_valid) begin
      pulses = pulses + 1;
      if (prev_valid) consec = consec + 1;
    end
    prev_valid = bus.count_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " count_out"},   bus.count_out,          8'h00);
    check({tag, " count_valid"}, {7'd0, bus.count_valid}, 8'h00);
    check({tag, " match_irq"},   {7'd0, bus.match_irq},   8'h00);
    check({tag, " skip_err"},    {7'd0, bus.skip_err},    8'h00);
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    bus.q_in = v;
    tick(n);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    pulses      = 0;
    consec      = 0;
    prev_valid  = 1'b0;
    rst         = 1'b1;
    bus.q_in      = 4'd0;
    bus.match_val = 4'd0;
    bus.match_en  = 1'b0;
    bus.irq_ack   = 1'b0;

    tick(2);
    check_zero_outputs("reset");
    rst = 1'b0;
    tick(10);
    check("idle_after_reset pulses", 8'(pulses), 8'd0);

    // 0 -> 1: valid exactly at the fifth edge after the change
    bus.q_in = 4'd1;
    tick(4);
    check("lat edge4 valid", {7'd0, bus.count_valid}, 8'h00);
    check("lat edge4 count", bus.count_out, 8'h00);
    tick(1);
    check("lat edge5 valid", {7'd0, bus.count_valid}, 8'h01);
    check("lat edge5 count", bus.count_out, 8'h01);
    tick(1);
    check("lat edge6 valid", {7'd0, bus.count_valid}, 8'h00);

    // full sweep to 15 then wrap to 0
    for (int v = 2; v <= 16; v++) begin
      hold(4'(v), 6);
    end
    check("sweep pulses", 8'(pulses), 8'd16);
    check("sweep count", bus.count_out, 8'h10);
    check("sweep skip", {7'd0, bus.skip_err}, 8'h00);

    // glitch rejection: 3 -> 7 (one cycle) -> 4
    hold(4'd1, 6);
    hold(4'd2, 6);
    hold(4'd3, 6);
    check("pre_glitch count", bus.count_out, 8'h13);
    hold(4'd7, 1);
    hold(4'd4, 8);
    check("glitch count", bus.count_out, 8'h14);
    check("glitch pulses", 8'(pulses), 8'd20);
    check("glitch skip", {7'd0, bus.skip_err}, 8'h00);

    // skip 2 -> 9
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hold(4'd1, 6);
    hold(4'd2, 6);
    check("pre_skip skip", {7'd0, bus.skip_err}, 8'h00);
    hold(4'd9, 6);
    check("skip count", bus.count_out, 8'h09);
    check("skip flag", {7'd0, bus.skip_err}, 8'h01);
    hold(4'd10, 6);
    check("skip sticky count", bus.count_out, 8'h0A);
    check("skip sticky flag", {7'd0, bus.skip_err}, 8'h01);
    check("skip pulses", 8'(pulses), 8'd24);

    // match with simultaneous ack: set wins, then ack clears
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("reset2 skip", {7'd0, bus.skip_err}, 8'h00);
    bus.match_en  = 1'b1;
    bus.match_val = 4'd5;
    for (int v = 1; v <= 4; v++) begin
      hold(4'(v), 6);
    end
    check("pre_match irq", {7'd0, bus.match_irq}, 8'h00);
    bus.irq_ack = 1'b1;
    bus.q_in    = 4'd5;
    tick(4);
    check("match edge4 irq", {7'd0, bus.match_irq}, 8'h00);
    tick(1);
    check("match set_wins irq", {7'd0, bus.match_irq}, 8'h01);
    check("match count", bus.count_out, 8'h05);
    tick(1);
    check("match ack irq", {7'd0, bus.match_irq}, 8'h00);
    bus.irq_ack = 1'b0;

    // sticky without ack, then ack
    bus.match_val = 4'd6;
    hold(4'd6, 6);
    tick(3);
    check("match sticky irq", {7'd0, bus.match_irq}, 8'h01);
    bus.irq_ack = 1'b1;
    tick(1);
    check("match ack2 irq", {7'd0, bus.match_irq}, 8'h00);
    bus.irq_ack = 1'b0;

    // match disabled
    bus.match_en  = 1'b0;
    bus.match_val = 4'd7;
    hold(4'd7, 6);
    check("match_dis irq", {7'd0, bus.match_irq}, 8'h00);
    check("match_dis count", bus.count_out, 8'h07);
    check("match pulses", 8'(pulses), 8'd31);

    // reset in SETTLE abandons candidate
    bus.q_in = 4'd8;
    tick(3);
    rst = 1'b1;
    bus.q_in = 4'd0;
    #1;
    check_zero_outputs("rst_settle");
    tick(2);
    rst = 1'b0;
    tick(10);
    check("rst_settle pulses", 8'(pulses), 8'd31);
    check("rst_settle count", bus.count_out, 8'h00);

    // reset in ACCEPT abandons candidate
    bus.q_in = 4'd1;
    tick(4);
    rst = 1'b1;
    bus.q_in = 4'd0;
    #1;
    check_zero_outputs("rst_accept");
    tick(2);
    rst = 1'b0;
    tick(10);
    check("rst_accept pulses", 8'(pulses), 8'd31);
    check("rst_accept count", bus.count_out, 8'h00);

    check("no_consecutive_valid", 8'(consec), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
